// File: rtl/jk_excitation_driver.sv
// JK excitation driver: steps an N-bit JK register toward a handshaked target,
// generating J/K inputs in parallel or lowest-bit-first serial order.
module jk_excitation_driver #(
    parameter int WIDTH = 4,
    parameter int SW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             step_mode,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             busy,
    output logic             done,
    output logic [SW-1:0]    steps
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] tgt_q;
    logic             mode_q;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] sel;
    logic             accept;

    assign accept    = tgt_valid && (state == IDLE);
    assign tgt_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == FIN);
    assign qn        = ~q;

    // Two's-complement trick isolates the lowest set bit of diff.
    assign diff = q ^ tgt_q;
    assign low  = diff & (~diff + WIDTH'(1));
    assign sel  = mode_q ? low : diff;

    always_comb begin
        state_d = state;
        j_out   = '0;
        k_out   = '0;
        unique case (state)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (diff == '0) begin
                    state_d = FIN;
                end else begin
                    j_out = sel & tgt_q;
                    k_out = sel & q;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            tgt_q  <= '0;
            mode_q <= 1'b0;
            q      <= '0;
            steps  <= '0;
        end else begin
            state <= state_d;
            q     <= (j_out & ~q) | (~k_out & q);
            if (accept) begin
                tgt_q  <= tgt_data;
                mode_q <= step_mode;
                steps  <= '0;
            end else if ((|(j_out | k_out)) && (steps != '1)) begin
                steps <= steps + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Self-checking bench for jk_excitation_driver: directed cases plus random jobs
// against a per-job excitation trace model.
module tb_jk_excitation_driver;

    localparam int W  = 4;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          tgt_valid;
    logic [W-1:0]  tgt_data;
    logic          step_mode;
    logic          tgt_ready;
    logic [W-1:0]  j_out, k_out, q, qn;
    logic          busy, done;
    logic [SW-1:0] steps;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] mq = '0;
    logic [SW-1:0] last_steps;

    jk_excitation_driver #(.WIDTH(W), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_data  (tgt_data),
        .step_mode (step_mode),
        .tgt_ready (tgt_ready),
        .j_out     (j_out),
        .k_out     (k_out),
        .q         (q),
        .qn        (qn),
        .busy      (busy),
        .done      (done),
        .steps     (steps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] nq;
        nq = ~q;
        chk("j_and_k", j_out & k_out, 0);
        chk("qn_inv", qn, nq);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected excitations are derived from the bit transitions themselves:
    // serial visits differing bits in ascending index order, parallel all at once.
    task automatic run_job(input logic [W-1:0] t, input logic m,
                           input logic hold, input logic [W-1:0] alt,
                           input logic alt_m);
        logic [W-1:0] ej[$];
        logic [W-1:0] ek[$];
        logic [W-1:0] d;
        logic [W-1:0] b;
        d = mq ^ t;
        if (m) begin
            for (int i = 0; i < W; i++) begin
                b = W'(1) << i;
                if (d[i]) begin
                    ej.push_back(t & b);
                    ek.push_back(mq & b);
                end
            end
        end else if (d != '0) begin
            ej.push_back(t & d);
            ek.push_back(mq & d);
        end
        chk("idle_ready", tgt_ready, 1);
        tgt_valid = 1'b1;
        tgt_data  = t;
        step_mode = m;
        tick();
        if (hold) begin
            tgt_data  = alt;
            step_mode = alt_m;
        end else begin
            tgt_valid = 1'b0;
            tgt_data  = W'($urandom);
            step_mode = 1'($urandom);
        end
        for (int n = 0; n < ej.size(); n++) begin
            chk("run_busy", busy, 1);
            chk("run_notready", tgt_ready, 0);
            chk("run_j", j_out, ej[n]);
            chk("run_k", k_out, ek[n]);
            tick();
            mq = (mq & ~ek[n]) | ej[n];
            chk("run_q", q, mq);
        end
        chk("settle_busy", busy, 1);
        chk("settle_j", j_out, 0);
        chk("settle_k", k_out, 0);
        chk("settle_done", done, 0);
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_notready", tgt_ready, 0);
        chk("done_steps", steps, ej.size());
        chk("done_q", q, mq);
        last_steps = steps;
        tick();
        chk("post_done", done, 0);
        chk("post_ready", tgt_ready, 1);
        chk("post_steps", steps, ej.size());
    endtask

    initial begin
        logic [W-1:0] t, alt;
        logic m, am, h;
        rst       = 1'b1;
        tgt_valid = 1'b0;
        tgt_data  = '0;
        step_mode = 1'b0;
        #12;
        chk("rst_q", q, 0);
        chk("rst_qn", qn, 4'b1111);
        chk("rst_ready", tgt_ready, 1);
        chk("rst_steps", steps, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        run_job(4'b1011, 1'b1, 1'b0, '0, 1'b0);
        chk("serial_qn", qn, 4'b0100);
        run_job(4'b0110, 1'b0, 1'b0, '0, 1'b0);
        run_job(4'b0110, 1'b0, 1'b0, '0, 1'b1);
        run_job(4'b1100, 1'b0, 1'b1, 4'b0011, 1'b1);
        run_job(4'b0011, 1'b1, 1'b0, '0, 1'b0);

        run_job(4'b1010, 1'b0, 1'b0, '0, 1'b0);
        chk("pre_rst_q", q, 4'b1010);
        #2;
        rst = 1'b1;
        #1;
        chk("async_q", q, 0);
        chk("async_qn", qn, 4'b1111);
        chk("async_ready", tgt_ready, 1);
        chk("async_steps", steps, 0);
        rst = 1'b0;
        mq  = '0;
        tick();

        tgt_valid = 1'b1;
        tgt_data  = 4'b1111;
        step_mode = 1'b1;
        tick();
        tgt_valid = 1'b0;
        tick();
        tick();
        chk("mid_q", q, 4'b0011);
        chk("mid_steps", steps, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_q", q, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_j", j_out, 0);
        chk("midrst_steps", steps, 0);
        chk("midrst_ready", tgt_ready, 1);
        rst = 1'b0;
        mq  = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_done", done, 0);
            chk("no_busy", busy, 0);
        end

        for (int i = 0; i < 30; i++) begin
            t   = W'($urandom);
            m   = 1'($urandom);
            h   = ($urandom_range(0, 3) == 0);
            alt = W'($urandom);
            am  = 1'($urandom);
            run_job(t, m, h, alt, am);
            if (h) run_job(alt, am, 1'b0, '0, 1'b0);
        end

        tgt_valid = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
